// File: rtl/instruction_loader.sv
// Assembles MSB-first byte streams into instruction words and writes them to
// instruction memory until a halt word is written or the memory is full.
module instruction_loader #(
    parameter int unsigned MEMORY_WIDTH = 32,
    parameter int unsigned MEMORY_DEPTH = 64,
    parameter int unsigned NB_ADDR      = 32,
    parameter int unsigned NB_BYTE      = 8,
    parameter logic [MEMORY_WIDTH-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic                    i_start,
    input  logic                    i_rx_valid,
    input  logic [NB_BYTE-1:0]      i_rx_data,
    output logic                    o_write_enable,
    output logic [NB_ADDR-1:0]      o_write_addr,
    output logic [MEMORY_WIDTH-1:0] o_write_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [NB_ADDR-1:0]      o_word_count
);

    typedef enum logic [1:0] {IDLE, RECEIVE, WRITE, DONE} state_t;

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEMORY_DEPTH - 1);

    state_t                   r_state;
    logic [1:0]               r_byte_cnt;
    logic [3*NB_BYTE-1:0]     r_buffer;
    logic [NB_ADDR-1:0]       r_addr;

    logic [MEMORY_WIDTH-1:0]  w_shifted;
    logic                     w_last_word;

    // Only three bytes are ever held; the fourth completes the word directly.
    assign w_shifted   = {r_buffer, i_rx_data};
    assign w_last_word = (o_write_data == HALT_WORD) || (r_addr == LAST_ADDR);

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state        <= IDLE;
            r_byte_cnt     <= '0;
            r_buffer       <= '0;
            r_addr         <= '0;
            o_write_enable <= 1'b0;
            o_write_addr   <= '0;
            o_write_data   <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_word_count   <= '0;
        end else begin
            o_write_enable <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_state      <= RECEIVE;
                        r_byte_cnt   <= '0;
                        r_buffer     <= '0;
                        r_addr       <= '0;
                        o_word_count <= '0;
                        o_busy       <= 1'b1;
                        o_done       <= 1'b0;
                    end
                end
                RECEIVE: begin
                    if (i_rx_valid) begin
                        r_buffer <= w_shifted[3*NB_BYTE-1:0];
                        if (r_byte_cnt == 2'd3) begin
                            r_byte_cnt     <= '0;
                            r_state        <= WRITE;
                            o_write_enable <= 1'b1;
                            o_write_addr   <= r_addr;
                            o_write_data   <= w_shifted;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    o_word_count <= o_word_count + NB_ADDR'(1);
                    if (w_last_word) begin
                        r_state <= DONE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end else begin
                        r_addr  <= r_addr + NB_ADDR'(1);
                        r_state <= RECEIVE;
                        // A byte arriving during the write starts the next word.
                        if (i_rx_valid) begin
                            r_buffer   <= w_shifted[3*NB_BYTE-1:0];
                            r_byte_cnt <= 2'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: expected memory writes are queued as
// bytes are driven and checked by a monitor whenever the write strobe fires.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        o_write_enable;
    logic [31:0] o_write_addr;
    logic [31:0] o_write_data;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_word_count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t q[$];
    int n_checks = 0;
    int n_fail   = 0;

    instruction_loader #(.MEMORY_DEPTH(4)) dut (
        .i_clock        (clk),
        .i_reset_n      (i_reset_n),
        .i_start        (i_start),
        .i_rx_valid     (i_rx_valid),
        .i_rx_data      (i_rx_data),
        .o_write_enable (o_write_enable),
        .o_write_addr   (o_write_addr),
        .o_write_data   (o_write_data),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_word_count   (o_word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit expect_write);
        wr_t e;
        if (expect_write) begin
            e.addr = addr;
            e.data = w;
            q.push_back(e);
        end
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
    endtask

    // Scoreboard monitor: every strobe must match the oldest pending write.
    always @(negedge clk) begin
        if (o_write_enable === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_write_addr", {32'h0, o_write_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = q.pop_front();
                check("write_addr", {32'h0, o_write_addr}, {32'h0, e.addr});
                check("write_data", {32'h0, o_write_data}, {32'h0, e.data});
            end
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_we",    {63'h0, o_write_enable}, 64'h0);
        check("rst_addr",  {32'h0, o_write_addr},   64'h0);
        check("rst_data",  {32'h0, o_write_data},   64'h0);
        check("rst_busy",  {63'h0, o_busy},         64'h0);
        check("rst_done",  {63'h0, o_done},         64'h0);
        check("rst_count", {32'h0, o_word_count},   64'h0);
        i_reset_n = 1'b1;
        tick();

        // Single word, write one cycle after the fourth byte
        pulse_start();
        check("busy_after_start", {63'h0, o_busy}, 64'h1);
        send_word(32'h20010005, 32'd0, 1'b1);
        check("we_after_4th", {63'h0, o_write_enable}, 64'h1);
        check("busy_in_write", {63'h0, o_busy}, 64'h1);
        tick();
        check("we_one_cycle", {63'h0, o_write_enable}, 64'h0);
        check("count_one", {32'h0, o_word_count}, 64'd1);
        check("busy_receive", {63'h0, o_busy}, 64'h1);
        pulse_start();
        send_byte(8'h55);
        tick();
        check("queue_empty_t1", 64'(q.size()), 64'd0);

        // Halt word terminates the load after being written
        do_reset();
        pulse_start();
        send_word(32'h00000001, 32'd0, 1'b1);
        tick();
        send_word(32'hFFFFFFFF, 32'd1, 1'b1);
        tick();
        check("halt_done",  {63'h0, o_done},       64'h1);
        check("halt_busy",  {63'h0, o_busy},       64'h0);
        check("halt_count", {32'h0, o_word_count}, 64'd2);
        send_word(32'h12345678, 32'd0, 1'b0);
        tick();
        check("done_hold", {63'h0, o_done}, 64'h1);

        // Reload from DONE
        pulse_start();
        check("reload_count_clr", {32'h0, o_word_count}, 64'd0);
        send_word(32'hDEADBEEF, 32'd0, 1'b1);
        tick();
        check("reload_busy",  {63'h0, o_busy},       64'h1);
        check("reload_done",  {63'h0, o_done},       64'h0);
        check("reload_count", {32'h0, o_word_count}, 64'd1);

        // Byte strobed during WRITE becomes byte 1 of the next word
        do_reset();
        pulse_start();
        send_word(32'h01020304, 32'd0, 1'b1);
        send_word(32'h11AABBCC, 32'd1, 1'b1);
        tick();
        check("overlap_count", {32'h0, o_word_count}, 64'd2);

        // Memory full: DEPTH=4 words, no halt word
        do_reset();
        pulse_start();
        for (int w = 0; w < 4; w++) begin
            send_word(32'hA0B0C000 + 32'(w), 32'(w), 1'b1);
            if (w < 3) tick();
        end
        send_byte(8'h99);
        check("full_done",  {63'h0, o_done},       64'h1);
        check("full_busy",  {63'h0, o_busy},       64'h0);
        check("full_count", {32'h0, o_word_count}, 64'd4);
        send_word(32'h0BADF00D, 32'd0, 1'b0);
        tick();

        // Reset mid-word with start and valid asserted in the same cycle
        do_reset();
        pulse_start();
        send_byte(8'h12);
        send_byte(8'h34);
        i_reset_n  = 1'b0;
        i_start    = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h56;
        tick();
        i_reset_n  = 1'b1;
        i_start    = 1'b0;
        i_rx_valid = 1'b0;
        check("midrst_we",    {63'h0, o_write_enable}, 64'h0);
        check("midrst_addr",  {32'h0, o_write_addr},   64'h0);
        check("midrst_data",  {32'h0, o_write_data},   64'h0);
        check("midrst_busy",  {63'h0, o_busy},         64'h0);
        check("midrst_done",  {63'h0, o_done},         64'h0);
        check("midrst_count", {32'h0, o_word_count},   64'h0);
        send_word(32'h77777777, 32'd0, 1'b0);
        check("idle_ignores_rx", {63'h0, o_busy}, 64'h0);
        pulse_start();
        send_word(32'hCAFE0123, 32'd0, 1'b1);
        tick();
        tick();
        check("queue_empty_end", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
